rgb_gray_fb_writer: RTL and testbench

Downstream consumer of the UART/camera pixel assembly stage. Takes each assembled RGB888 pixel (rgb_data qualified by pixel_done), converts it to 8-bit luma, and writes it into a double-banked frame buffer. It publishes each completed frame to the image-processing/plotter path and owns bank ping-pong, overflow dropping and frame resynchronisation.

---
 rtl/rgb_gray_fb_writer_pkg.sv | 20 ++
 rtl/rgb_gray_fb_writer_rgb2gray_pipe.sv | 55 +++++
 rtl/rgb_gray_fb_writer.sv | 157 +++++++++++++++
 tb/tb_rgb_gray_fb_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_gray_fb_writer_pkg.sv
// Shared types and luma constants for the RGB-to-gray frame-buffer writer.
package fb_writer_pkg;

   typedef enum logic [1:0] {
      ST_WRITE     = 2'd0,
      ST_WAIT_BANK = 2'd1,
      ST_DROP      = 2'd2
   } state_t;

   typedef enum logic {
      BANK_FREE = 1'b0,
      BANK_FULL = 1'b1
   } bank_state_t;

   localparam int COEF_R     = 77;
   localparam int COEF_G     = 150;
   localparam int COEF_B     = 29;
   localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/rgb_gray_fb_writer_rgb2gray_pipe.sv
// Two-stage luma pipeline: S1 registers the channel products, S2 their sum.
// Pixel and frame tags travel alongside so downstream sees them aligned with gray.
module rgb2gray_pipe
   import fb_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3*DATA_WIDTH-1:0] rgb_data,
   input  logic                    pixel_done,
   input  logic                    frame_done,
   output logic                    out_pix,
   output logic                    out_frame,
   output logic [DATA_WIDTH-1:0]   gray
);

   localparam int SW = 2 * DATA_WIDTH;

   logic [SW-1:0] prod_r;
   logic [SW-1:0] prod_g;
   logic [SW-1:0] prod_b;
   logic [SW-1:0] sum;
   logic          s1_pix;
   logic          s1_frame;

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_r    <= '0;
         prod_g    <= '0;
         prod_b    <= '0;
         s1_pix    <= 1'b0;
         s1_frame  <= 1'b0;
         sum       <= '0;
         out_pix   <= 1'b0;
         out_frame <= 1'b0;
      end else begin
         prod_r    <= SW'(rgb_data[3*DATA_WIDTH-1 -: DATA_WIDTH]) * SW'(COEF_R);
         prod_g    <= SW'(rgb_data[2*DATA_WIDTH-1 -: DATA_WIDTH]) * SW'(COEF_G);
         prod_b    <= SW'(rgb_data[DATA_WIDTH-1 -: DATA_WIDTH])   * SW'(COEF_B);
         s1_pix    <= pixel_done;
         s1_frame  <= frame_done;
         sum       <= prod_r + prod_g + prod_b;
         out_pix   <= s1_pix;
         out_frame <= s1_frame;
      end
   end

   // Truncating shift: low bits of the sum are intentionally discarded.
   assign gray = sum[LUMA_SHIFT +: DATA_WIDTH];

   logic unused_lsb;
   assign unused_lsb = ^sum[LUMA_SHIFT-1:0];

endmodule

// File: rtl/rgb_gray_fb_writer.sv
// Gray frame-buffer writer: ping-pong banks, frame publish, overflow drop, resync.
//   state        | meaning
//   ST_WRITE     | writing pixels into bank wbank
//   ST_WAIT_BANK | both banks full, waiting for a release
//   ST_DROP      | no bank was available, discarding rest of frame
module rgb_gray_fb_writer
   import fb_writer_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int TOTAL_PIXELS = 9600,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3*DATA_WIDTH-1:0] rgb_data,
   input  logic                    pixel_done,
   input  logic                    frame_done,
   input  logic                    buf_release,
   input  logic                    buf_release_bank,
   output logic                    wr_en,
   output logic [ADDR_WIDTH:0]     wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    frame_ready,
   output logic                    ready_bank,
   output logic                    overflow
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_PIXELS - 1);

   logic                  out_pix;
   logic                  out_frame;
   logic [DATA_WIDTH-1:0] gray;

   state_t                state;
   state_t                state_n;
   bank_state_t           bank_state [2];
   logic                  wbank;
   logic                  wbank_n;
   logic [ADDR_WIDTH-1:0] index;
   logic                  sat;

   logic [1:0] free_eff;
   logic       any_free;
   logic       free_bank;
   logic       eff_bank;
   logic       other_free;
   logic       can_write;
   logic       pix_ok;
   logic       complete;
   logic       drop;

   rgb2gray_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
      .clk        (clk),
      .reset      (reset),
      .rgb_data   (rgb_data),
      .pixel_done (pixel_done),
      .frame_done (frame_done),
      .out_pix    (out_pix),
      .out_frame  (out_frame),
      .gray       (gray)
   );

   // A release in this cycle already counts as a free bank.
   assign free_eff[0] = (bank_state[0] == BANK_FREE) || (buf_release && !buf_release_bank);
   assign free_eff[1] = (bank_state[1] == BANK_FREE) || (buf_release && buf_release_bank);
   assign any_free    = |free_eff;
   assign free_bank   = free_eff[0] ? 1'b0 : 1'b1;
   assign eff_bank    = (state == ST_WRITE) ? wbank : free_bank;
   assign other_free  = eff_bank ? free_eff[0] : free_eff[1];
   assign can_write   = (state == ST_WRITE) || ((state == ST_WAIT_BANK) && any_free);
   assign pix_ok      = out_pix && can_write && !sat;
   assign complete    = pix_ok && out_frame && (index == LAST_IDX);
   assign drop        = out_pix && !pix_ok;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_WRITE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      wbank_n = wbank;
      case (state)
         ST_WRITE: begin
            if (complete) begin
               if (other_free) wbank_n = ~eff_bank;
               else            state_n = ST_WAIT_BANK;
            end
         end
         ST_WAIT_BANK: begin
            if (any_free) begin
               wbank_n = free_bank;
               state_n = ST_WRITE;
               if (complete) begin
                  if (other_free) wbank_n = ~eff_bank;
                  else            state_n = ST_WAIT_BANK;
               end
            end else if (out_pix && !out_frame) begin
               state_n = ST_DROP;
            end
         end
         ST_DROP: begin
            if (out_frame) begin
               if (any_free) begin
                  wbank_n = free_bank;
                  state_n = ST_WRITE;
               end else begin
                  state_n = ST_WAIT_BANK;
               end
            end
         end
         default: state_n = ST_WRITE;
      endcase
   end

   always_comb begin
      wr_en       = pix_ok;
      wr_addr     = '0;
      wr_data     = '0;
      frame_ready = complete;
      if (pix_ok) begin
         wr_addr = {eff_bank, index};
         wr_data = gray;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wbank         <= 1'b0;
         bank_state[0] <= BANK_FREE;
         bank_state[1] <= BANK_FREE;
         index         <= '0;
         sat           <= 1'b0;
         ready_bank    <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         wbank    <= wbank_n;
         overflow <= overflow | drop;
         if (complete) ready_bank <= eff_bank;
         // Publishing takes priority over a release of the same bank.
         for (int b = 0; b < 2; b++) begin
            if (complete && (eff_bank == 1'(b)))
               bank_state[b] <= BANK_FULL;
            else if (buf_release && (buf_release_bank == 1'(b)) && (bank_state[b] == BANK_FULL))
               bank_state[b] <= BANK_FREE;
         end
         if (out_frame) begin
            index <= '0;
            sat   <= 1'b0;
         end else if (out_pix) begin
            if (index == LAST_IDX) sat   <= 1'b1;
            else                   index <= index + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rgb_gray_fb_writer.sv
// Directed bench for rgb_gray_fb_writer with a 4-pixel frame and 4-bit bank index.
module tb_rgb_gray_fb_writer;
   import fb_writer_pkg::*;

   localparam int DW = 8;
   localparam int TP = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [23:0]   rgb_data = '0;
   logic          pixel_done = 1'b0;
   logic          frame_done = 1'b0;
   logic          buf_release = 1'b0;
   logic          buf_release_bank = 1'b0;
   logic          wr_en;
   logic [AW:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic          frame_ready;
   logic          ready_bank;
   logic          overflow;

   int total = 0;
   int bad = 0;

   logic [23:0] pix  [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
   logic [7:0]  gray [4] = '{8'd255, 8'd76, 8'd149, 8'd28};

   rgb_gray_fb_writer #(.DATA_WIDTH(DW), .TOTAL_PIXELS(TP), .ADDR_WIDTH(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .rgb_data         (rgb_data),
      .pixel_done       (pixel_done),
      .frame_done       (frame_done),
      .buf_release      (buf_release),
      .buf_release_bank (buf_release_bank),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .frame_ready      (frame_ready),
      .ready_bank       (ready_bank),
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      pixel_done  = 1'b0;
      frame_done  = 1'b0;
      buf_release = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   // Four pixels, frame_done on the last; writes land two cycles after each strobe.
   task automatic send_frame(input int base, input bit expect_wr, input int rel_slot,
                             input logic rel_b, input logic exp_rb);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            pixel_done = 1'b1;
            rgb_data   = pix[i];
            frame_done = (i == 3);
         end
         if (i == rel_slot) begin
            buf_release      = 1'b1;
            buf_release_bank = rel_b;
         end
         #1;
         if (i >= 2) begin
            chk("wr_en", 32'(wr_en), 32'(expect_wr));
            if (expect_wr) begin
               chk("wr_addr", 32'(wr_addr), 32'(base + i - 2));
               chk("wr_data", 32'(wr_data), 32'(gray[i-2]));
            end
            chk("frame_ready", 32'(frame_ready), 32'(expect_wr && (i == 5)));
         end
         next_cycle();
      end
      if (expect_wr) chk("ready_bank", 32'(ready_bank), 32'(exp_rb));
   endtask

   initial begin
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_frame_ready", 32'(frame_ready), 32'd0);
      chk("rst_ready_bank", 32'(ready_bank), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_state", 32'(dut.state), 32'(ST_WRITE));
      next_cycle();

      // single frame into bank 0
      send_frame(0, 1'b1, -1, 1'b0, 1'b0);

      // second frame into bank 1, then third frame fully dropped
      send_frame(16, 1'b1, -1, 1'b0, 1'b1);
      #1;
      chk("wait_state", 32'(dut.state), 32'(ST_WAIT_BANK));
      chk("no_ovf_yet", 32'(overflow), 32'd0);
      next_cycle();
      send_frame(0, 1'b0, -1, 1'b0, 1'b0);
      #1;
      chk("drop_overflow", 32'(overflow), 32'd1);
      chk("drop_state", 32'(dut.state), 32'(ST_WAIT_BANK));
      next_cycle();

      // release coincides with first out pixel while waiting
      do_reset();
      send_frame(0, 1'b1, -1, 1'b0, 1'b0);
      send_frame(16, 1'b1, -1, 1'b0, 1'b1);
      send_frame(0, 1'b1, 2, 1'b0, 1'b0);
      #1;
      chk("rel_overflow", 32'(overflow), 32'd0);
      chk("rel_state", 32'(dut.state), 32'(ST_WAIT_BANK));
      buf_release      = 1'b1;
      buf_release_bank = 1'b1;
      next_cycle();
      #1;
      chk("rel1_state", 32'(dut.state), 32'(ST_WRITE));

      // short frame: two pixels then a lone frame_done, bank 1 is rewritten
      for (int i = 0; i < 6; i++) begin
         if (i < 2) begin
            pixel_done = 1'b1;
            rgb_data   = pix[i];
         end
         if (i == 2) frame_done = 1'b1;
         #1;
         if (i == 2 || i == 3) begin
            chk("short_wr_en", 32'(wr_en), 32'd1);
            chk("short_addr", 32'(wr_addr), 32'(16 + i - 2));
            chk("short_data", 32'(wr_data), 32'(gray[i-2]));
         end
         if (i == 4) chk("short_no_wr", 32'(wr_en), 32'd0);
         if (i >= 2) chk("short_no_ready", 32'(frame_ready), 32'd0);
         if (i == 5) chk("short_index", 32'(dut.index), 32'd0);
         next_cycle();
      end
      send_frame(16, 1'b1, -1, 1'b0, 1'b1);

      // lone frame_done with no pixels
      do_reset();
      frame_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("lone_wr_en", 32'(wr_en), 32'd0);
         chk("lone_ready", 32'(frame_ready), 32'd0);
         next_cycle();
      end
      #1;
      chk("lone_index", 32'(dut.index), 32'd0);
      send_frame(0, 1'b1, -1, 1'b0, 1'b0);

      // over-long frame: fifth pixel dropped at the saturated index, then resync
      for (int i = 0; i < 11; i++) begin
         if (i < 5) begin
            pixel_done = 1'b1;
            rgb_data   = pix[i % 4];
         end
         if (i == 7) frame_done = 1'b1;
         #1;
         if (i >= 2 && i <= 5) begin
            chk("long_wr_en", 32'(wr_en), 32'd1);
            chk("long_addr", 32'(wr_addr), 32'(16 + i - 2));
            chk("long_data", 32'(wr_data), 32'(gray[i-2]));
         end
         if (i == 6) chk("long_drop_wr", 32'(wr_en), 32'd0);
         if (i == 6) chk("long_ovf_before", 32'(overflow), 32'd0);
         if (i == 7) chk("long_ovf", 32'(overflow), 32'd1);
         if (i >= 2) chk("long_no_ready", 32'(frame_ready), 32'd0);
         if (i == 10) begin
            chk("long_index", 32'(dut.index), 32'd0);
            chk("long_state", 32'(dut.state), 32'(ST_WRITE));
         end
         next_cycle();
      end

      // reset in the middle of a frame
      for (int i = 0; i < 3; i++) begin
         if (i < 2) begin
            pixel_done = 1'b1;
            rgb_data   = pix[i];
         end
         #1;
         if (i == 2) begin
            chk("mid_wr_en", 32'(wr_en), 32'd1);
            chk("mid_addr", 32'(wr_addr), 32'd16);
            reset = 1'b1;
         end
         next_cycle();
      end
      reset = 1'b0;
      #1;
      chk("mrst_wr_en", 32'(wr_en), 32'd0);
      chk("mrst_overflow", 32'(overflow), 32'd0);
      chk("mrst_bank0", 32'(dut.bank_state[0]), 32'(BANK_FREE));
      chk("mrst_bank1", 32'(dut.bank_state[1]), 32'(BANK_FREE));
      chk("mrst_state", 32'(dut.state), 32'(ST_WRITE));
      next_cycle();
      #1;
      chk("mrst_wr_en2", 32'(wr_en), 32'd0);
      next_cycle();
      send_frame(0, 1'b1, -1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
